// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared constants, state encoding and region decode for the PPU VRAM controller
package ppu_pkg;

  localparam logic [13:0] CHR_BASE = 14'h0000;
  localparam logic [13:0] NT_BASE  = 14'h2000;
  localparam logic [13:0] PAL_BASE = 14'h3F00;

  localparam logic [1:0] MIR_H = 2'd0;
  localparam logic [1:0] MIR_V = 2'd1;
  localparam logic [1:0] MIR_A = 2'd2;
  localparam logic [1:0] MIR_B = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAL,
    ST_NT_RD,
    ST_NT_WR,
    ST_CHR_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    REG_CHR,
    REG_NT,
    REG_PAL
  } region_t;

  // Palette wins over NT for $3F00-$3FFF; everything below $2000 is CHR.
  function automatic region_t decode_region(input logic [13:0] addr);
    if (addr[13:8] == PAL_BASE[13:8])
      return REG_PAL;
    else if (addr[13] == CHR_BASE[13])
      return REG_CHR;
    else if (addr[13] == NT_BASE[13])
      return REG_NT;
    else
      return REG_NT;
  endfunction

endpackage

// File: rtl/ppu_vram_ctrl_if.sv
// rtl/ppu_vram_ctrl_if.sv - PPU core memory request port
interface ppu_vram_ctrl_if;
  logic [13:0] ppu_addr;
  logic [7:0]  ppu_wdata;
  logic        ppu_rd_req;
  logic        ppu_wr_req;
  logic [7:0]  ppu_rdata;
  logic        ppu_ack;
  logic        ppu_busy;

  modport master (
    output ppu_addr, ppu_wdata, ppu_rd_req, ppu_wr_req,
    input  ppu_rdata, ppu_ack, ppu_busy
  );

  modport slave (
    input  ppu_addr, ppu_wdata, ppu_rd_req, ppu_wr_req,
    output ppu_rdata, ppu_ack, ppu_busy
  );
endinterface

// File: rtl/ppu_vram_ram.sv
// rtl/ppu_vram_ram.sv - single-port synchronous RAM with one-cycle read latency
module ppu_vram_ram #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    if (en)
      q <= mem[addr];
  end

endmodule

// File: rtl/ppu_vram_ctrl.sv
// rtl/ppu_vram_ctrl.sv - decodes PPU requests into CHR port, mirrored nametable RAM and palette RAM
module ppu_vram_ctrl
  import ppu_pkg::*;
#(
  parameter int CHR_TIMEOUT = 15,
  parameter int PAL_WIDTH   = 6,
  parameter int VRAM_AW     = 11
) (
  input  logic        clk,
  input  logic        rst,
  ppu_vram_ctrl_if.slave ppu,
  input  logic [1:0]  mirror_mode,
  output logic [12:0] chr_addr,
  output logic        chr_rd,
  output logic        chr_wr,
  output logic [7:0]  chr_wdata,
  input  logic [7:0]  chr_rdata,
  input  logic        chr_ready,
  output logic        chr_err
);

  state_t        state;
  logic          busy_q, ack_q, err_q, rd_q, wr_strobe_q, wr_q, rd_pend;
  logic [7:0]    rdata_q, wdata_q, cnt;
  logic [12:0]   addr_q;
  logic [1:0]    mode_q;
  logic          mir_bit;
  logic [4:0]    pidx;
  logic [7:0]    ram_q;
  logic [PAL_WIDTH-1:0] pal [32];

  always_comb begin
    mir_bit = 1'b0;
    case (mode_q)
      MIR_H:   mir_bit = addr_q[11];
      MIR_V:   mir_bit = addr_q[10];
      MIR_A:   mir_bit = 1'b0;
      MIR_B:   mir_bit = 1'b1;
      default: mir_bit = 1'b0;
    endcase
  end

  // $3F10/14/18/1C fold onto the backdrop entries $3F00/04/08/0C.
  assign pidx = {addr_q[4] & (addr_q[1:0] != 2'b00), addr_q[3:0]};

  ppu_vram_ram #(.AW(VRAM_AW), .DW(8)) u_nt_ram (
    .clk   (clk),
    .we    (state == ST_NT_WR),
    .en    (state == ST_NT_RD && !rd_pend),
    .addr  (VRAM_AW'({mir_bit, addr_q[9:0]})),
    .wdata (wdata_q),
    .q     (ram_q)
  );

  always_ff @(posedge clk) begin
    if (state == ST_PAL && wr_q)
      pal[pidx] <= wdata_q[PAL_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_q        <= 1'b0;
      rd_pend     <= 1'b0;
      rdata_q     <= 8'h00;
      wdata_q     <= 8'h00;
      addr_q      <= 13'h0000;
      mode_q      <= MIR_H;
      cnt         <= 8'h00;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ppu.ppu_rd_req || ppu.ppu_wr_req) begin
            addr_q  <= ppu.ppu_addr[12:0];
            wdata_q <= ppu.ppu_wdata;
            wr_q    <= ppu.ppu_wr_req;
            mode_q  <= mirror_mode;
            busy_q  <= 1'b1;
            rd_pend <= 1'b0;
            case (decode_region(ppu.ppu_addr))
              REG_CHR: begin
                state       <= ST_CHR_WAIT;
                rd_q        <= !ppu.ppu_wr_req;
                wr_strobe_q <= ppu.ppu_wr_req;
                cnt         <= 8'd1;
              end
              REG_PAL: state <= ST_PAL;
              default: state <= ppu.ppu_wr_req ? ST_NT_WR : ST_NT_RD;
            endcase
          end
        end
        ST_PAL: begin
          if (!wr_q)
            rdata_q <= 8'(pal[pidx]);
          ack_q <= 1'b1;
          state <= ST_DONE;
        end
        ST_NT_WR: begin
          ack_q <= 1'b1;
          state <= ST_DONE;
        end
        ST_NT_RD: begin
          // First cycle issues the RAM read, second captures its registered output.
          if (rd_pend) begin
            rdata_q <= ram_q;
            ack_q   <= 1'b1;
            state   <= ST_DONE;
          end else begin
            rd_pend <= 1'b1;
          end
        end
        ST_CHR_WAIT: begin
          if (chr_ready) begin
            rd_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            if (!wr_q)
              rdata_q <= chr_rdata;
            ack_q <= 1'b1;
            state <= ST_DONE;
          end else if (cnt == 8'(CHR_TIMEOUT)) begin
            rd_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            if (!wr_q)
              rdata_q <= 8'h00;
            err_q <= 1'b1;
            ack_q <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ppu.ppu_rdata = rdata_q;
  assign ppu.ppu_ack   = ack_q;
  assign ppu.ppu_busy  = busy_q;
  assign chr_addr      = addr_q;
  assign chr_wdata     = wdata_q;
  assign chr_rd        = rd_q;
  assign chr_wr        = wr_strobe_q;
  assign chr_err       = err_q;

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// tb/tb_ppu_vram_ctrl.sv - directed self-checking bench for ppu_vram_ctrl
module tb_ppu_vram_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mirror_mode = 2'd0;
  logic [12:0] chr_addr;
  logic        chr_rd, chr_wr, chr_err;
  logic [7:0]  chr_wdata;
  logic [7:0]  chr_rdata = 8'h00;
  logic        chr_ready = 1'b0;
  int          vectors = 0;
  int          errors = 0;

  ppu_vram_ctrl_if bus ();

  ppu_vram_ctrl #(.CHR_TIMEOUT(15), .PAL_WIDTH(6), .VRAM_AW(11)) dut (
    .clk         (clk),
    .rst         (rst),
    .ppu         (bus),
    .mirror_mode (mirror_mode),
    .chr_addr    (chr_addr),
    .chr_rd      (chr_rd),
    .chr_wr      (chr_wr),
    .chr_wdata   (chr_wdata),
    .chr_rdata   (chr_rdata),
    .chr_ready   (chr_ready),
    .chr_err     (chr_err)
  );

  always #5 clk = ~clk;

  // Issues one request, waits (bounded) for ack, then samples busy one cycle later.
  task automatic access(input logic rd, input logic wr, input logic [13:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] q, output logic busy_after);
    bus.ppu_addr = a; bus.ppu_wdata = d; bus.ppu_rd_req = rd; bus.ppu_wr_req = wr;
    @(posedge clk); #1;
    bus.ppu_rd_req = 1'b0; bus.ppu_wr_req = 1'b0;
    lat = 0; q = 8'hxx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.ppu_ack === 1'b1) begin lat = n; q = bus.ppu_rdata; break; end
    end
    @(negedge clk);
    busy_after = bus.ppu_busy;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({bus.ppu_ack, bus.ppu_busy, bus.ppu_rdata, chr_rd, chr_wr, chr_err, chr_addr, chr_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b busy=%b rdata=%h rd=%b wr=%b err=%b addr=%h wdata=%h want all 0",
               bus.ppu_ack, bus.ppu_busy, bus.ppu_rdata, chr_rd, chr_wr, chr_err, chr_addr, chr_wdata);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vertical();
    int lat; logic [7:0] q; logic b;
    mirror_mode = 2'd1;
    access(0, 1, 14'h2405, 8'h00, lat, q, b);
    access(0, 1, 14'h2005, 8'hA5, lat, q, b);
    vectors++; if (lat !== 2) begin errors++; $display("FAIL v_nt_wr_lat got %0d want 2", lat); end
    vectors++; if (b !== 1'b0) begin errors++; $display("FAIL v_busy_fall got %b want 0", b); end
    access(1, 0, 14'h2805, 8'h00, lat, q, b);
    vectors++; if (lat !== 3) begin errors++; $display("FAIL v_nt_rd_lat got %0d want 3", lat); end
    vectors++; if (q !== 8'hA5) begin errors++; $display("FAIL v_rd_2805 got %h want a5", q); end
    access(1, 0, 14'h2405, 8'h00, lat, q, b);
    vectors++; if (q !== 8'h00) begin errors++; $display("FAIL v_rd_2405 got %h want 00", q); end
  endtask

  task automatic test_horizontal();
    int lat; logic [7:0] q; logic b;
    mirror_mode = 2'd0;
    access(0, 1, 14'h2C00, 8'h00, lat, q, b);
    access(0, 1, 14'h2400, 8'h3C, lat, q, b);
    access(1, 0, 14'h2000, 8'h00, lat, q, b);
    vectors++; if (q !== 8'h3C) begin errors++; $display("FAIL h_rd_2000 got %h want 3c", q); end
    access(1, 0, 14'h2C00, 8'h00, lat, q, b);
    vectors++; if (q !== 8'h00) begin errors++; $display("FAIL h_rd_2c00 got %h want 00", q); end
    access(1, 0, 14'h3400, 8'h00, lat, q, b);
    vectors++; if (q !== 8'h3C) begin errors++; $display("FAIL h_rd_3400_alias got %h want 3c", q); end
    mirror_mode = 2'd2;
    access(1, 0, 14'h2C00, 8'h00, lat, q, b);
    vectors++; if (q !== 8'h3C) begin errors++; $display("FAIL ssa_rd_2c00 got %h want 3c", q); end
    mirror_mode = 2'd3;
    access(1, 0, 14'h2000, 8'h00, lat, q, b);
    vectors++; if (q !== 8'h00) begin errors++; $display("FAIL ssb_rd_2000 got %h want 00", q); end
    // Mode flips to vertical right after acceptance; horizontal mapping must still apply.
    mirror_mode = 2'd0;
    bus.ppu_addr = 14'h2400; bus.ppu_rd_req = 1'b1;
    @(posedge clk); #1;
    bus.ppu_rd_req = 1'b0; mirror_mode = 2'd1;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus.ppu_ack === 1'b1) begin lat = n; q = bus.ppu_rdata; break; end
    end
    @(negedge clk);
    vectors++; if (lat !== 3 || q !== 8'h3C) begin errors++; $display("FAIL mirror_midchange got lat=%0d data=%h want lat=3 data=3c", lat, q); end
  endtask

  task automatic test_palette();
    int lat; logic [7:0] q; logic b;
    access(0, 1, 14'h3F01, 8'h2A, lat, q, b);
    access(0, 1, 14'h3F10, 8'hFF, lat, q, b);
    vectors++; if (lat !== 2) begin errors++; $display("FAIL pal_wr_lat got %0d want 2", lat); end
    access(1, 0, 14'h3F00, 8'h00, lat, q, b);
    vectors++; if (lat !== 2) begin errors++; $display("FAIL pal_rd_lat got %0d want 2", lat); end
    vectors++; if (q !== 8'h3F) begin errors++; $display("FAIL pal_rd_3f00 got %h want 3f", q); end
    access(0, 1, 14'h3F11, 8'h12, lat, q, b);
    vectors++; if (q !== 8'h3F) begin errors++; $display("FAIL pal_wr_keeps_rdata got %h want 3f", q); end
    access(1, 0, 14'h3F01, 8'h00, lat, q, b);
    vectors++; if (q !== 8'h2A) begin errors++; $display("FAIL pal_rd_3f01 got %h want 2a", q); end
    access(1, 0, 14'h3F11, 8'h00, lat, q, b);
    vectors++; if (q !== 8'h12) begin errors++; $display("FAIL pal_rd_3f11 got %h want 12", q); end
  endtask

  task automatic test_chr_read_late();
    int bad = 0;
    bus.ppu_addr = 14'h1ABC; bus.ppu_rd_req = 1'b1;
    @(posedge clk); #1; bus.ppu_rd_req = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (chr_rd !== 1'b1 || chr_wr !== 1'b0 || chr_addr !== 13'h1ABC || bus.ppu_ack !== 1'b0 || chr_err !== 1'b0) bad++;
      if (n == 5) begin chr_ready = 1'b1; chr_rdata = 8'h5A; end
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL chr_strobe_hold got %0d bad cycles want 0", bad); end
    @(negedge clk);
    chr_ready = 1'b0;
    vectors++;
    if (bus.ppu_ack !== 1'b1 || bus.ppu_rdata !== 8'h5A || chr_rd !== 1'b0 || chr_err !== 1'b0) begin
      errors++;
      $display("FAIL chr_rd_done got ack=%b rdata=%h rd=%b err=%b want 1 5a 0 0", bus.ppu_ack, bus.ppu_rdata, chr_rd, chr_err);
    end
    @(negedge clk);
    vectors++; if (bus.ppu_busy !== 1'b0) begin errors++; $display("FAIL chr_rd_busy got %b want 0", bus.ppu_busy); end
  endtask

  task automatic test_chr_write_fast();
    bus.ppu_addr = 14'h0123; bus.ppu_wdata = 8'h77; bus.ppu_wr_req = 1'b1;
    @(posedge clk); #1; bus.ppu_wr_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (chr_wr !== 1'b1 || chr_rd !== 1'b0 || chr_addr !== 13'h0123 || chr_wdata !== 8'h77) begin
      errors++;
      $display("FAIL chr_wr_strobe got wr=%b rd=%b addr=%h data=%h want 1 0 0123 77", chr_wr, chr_rd, chr_addr, chr_wdata);
    end
    chr_ready = 1'b1; chr_rdata = 8'hEE;
    @(negedge clk);
    chr_ready = 1'b0;
    vectors++;
    if (bus.ppu_ack !== 1'b1 || chr_wr !== 1'b0 || bus.ppu_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL chr_wr_done got ack=%b wr=%b rdata=%h want 1 0 5a", bus.ppu_ack, chr_wr, bus.ppu_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_chr_timeout();
    int bad = 0;
    bus.ppu_addr = 14'h0100; bus.ppu_rd_req = 1'b1;
    @(posedge clk); #1; bus.ppu_rd_req = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (chr_rd !== 1'b1 || chr_err !== 1'b0 || bus.ppu_ack !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL tmo_wait got %0d bad cycles want 0", bad); end
    @(negedge clk);
    vectors++;
    if (chr_err !== 1'b1 || bus.ppu_ack !== 1'b1 || bus.ppu_rdata !== 8'h00 || chr_rd !== 1'b0) begin
      errors++;
      $display("FAIL tmo_expire got err=%b ack=%b rdata=%h rd=%b want 1 1 00 0", chr_err, bus.ppu_ack, bus.ppu_rdata, chr_rd);
    end
    @(negedge clk);
    vectors++;
    if (bus.ppu_busy !== 1'b0 || chr_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_after got busy=%b err=%b want 0 0", bus.ppu_busy, chr_err);
    end
  endtask

  task automatic test_chr_ready_at_expiry();
    bus.ppu_addr = 14'h0200; bus.ppu_rd_req = 1'b1;
    @(posedge clk); #1; bus.ppu_rd_req = 1'b0;
    for (int n = 1; n <= 15; n++) @(negedge clk);
    chr_ready = 1'b1; chr_rdata = 8'hC3;
    @(negedge clk);
    chr_ready = 1'b0;
    vectors++;
    if (bus.ppu_ack !== 1'b1 || chr_err !== 1'b0 || bus.ppu_rdata !== 8'hC3) begin
      errors++;
      $display("FAIL tmo_boundary got ack=%b err=%b rdata=%h want 1 0 c3", bus.ppu_ack, chr_err, bus.ppu_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid_chr();
    int acks = 0;
    bus.ppu_addr = 14'h0300; bus.ppu_rd_req = 1'b1;
    @(posedge clk); #1; bus.ppu_rd_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (chr_rd !== 1'b0 || chr_wr !== 1'b0 || bus.ppu_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_strobe got rd=%b wr=%b busy=%b want 0 0 0", chr_rd, chr_wr, bus.ppu_busy);
    end
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.ppu_ack === 1'b1 || chr_err === 1'b1 || chr_rd === 1'b1) acks++;
    end
    vectors++; if (acks != 0) begin errors++; $display("FAIL rst_mid_no_ack got %0d events want 0", acks); end
  endtask

  task automatic test_rd_wr_both();
    int lat; logic [7:0] q; logic b;
    mirror_mode = 2'd1;
    access(1, 0, 14'h2005, 8'h00, lat, q, b);
    vectors++; if (q !== 8'hA5) begin errors++; $display("FAIL rdwr_pre got %h want a5", q); end
    access(1, 1, 14'h2005, 8'h66, lat, q, b);
    vectors++; if (lat !== 2 || q !== 8'hA5) begin errors++; $display("FAIL rdwr_as_write got lat=%0d rdata=%h want lat=2 rdata=a5", lat, q); end
    access(1, 0, 14'h2005, 8'h00, lat, q, b);
    vectors++; if (q !== 8'h66) begin errors++; $display("FAIL rdwr_stored got %h want 66", q); end
  endtask

  task automatic test_busy_ignore();
    int acks = 0; int lat; logic [7:0] q = 8'hxx; logic b;
    bus.ppu_addr = 14'h2005; bus.ppu_rd_req = 1'b1;
    @(posedge clk); #1;
    bus.ppu_rd_req = 1'b0; bus.ppu_wr_req = 1'b1; bus.ppu_wdata = 8'h11;
    @(posedge clk); #1;
    bus.ppu_wr_req = 1'b0;
    for (int n = 2; n <= 10; n++) begin
      @(negedge clk);
      if (bus.ppu_ack === 1'b1) begin acks++; q = bus.ppu_rdata; end
    end
    vectors++; if (acks != 1 || q !== 8'h66) begin errors++; $display("FAIL busy_ignore got acks=%0d rdata=%h want 1 66", acks, q); end
    access(1, 0, 14'h2005, 8'h00, lat, q, b);
    vectors++; if (q !== 8'h66) begin errors++; $display("FAIL busy_no_write got %h want 66", q); end
  endtask

  initial begin
    bus.ppu_addr = '0; bus.ppu_wdata = '0; bus.ppu_rd_req = 1'b0; bus.ppu_wr_req = 1'b0;
    test_reset();
    test_vertical();
    test_horizontal();
    test_palette();
    test_chr_read_late();
    test_chr_write_fast();
    test_chr_timeout();
    test_chr_ready_at_expiry();
    test_rst_mid_chr();
    test_rd_wr_both();
    test_busy_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
